// File: rtl/stream_element_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_element_counter_pkg
//  Description : Shared count type and saturating add used by keep-aware stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_element_counter_pkg;

    localparam int unsigned C_MAX_COUNT_WIDTH = 32;

    typedef logic [C_MAX_COUNT_WIDTH-1:0] count_t;
    typedef logic [C_MAX_COUNT_WIDTH:0]   wide_count_t;

    // Adds one bit wider than the operands and clamps to 2^width-1.
    function automatic count_t sat_add(
        input count_t      a,
        input count_t      b,
        input int unsigned width
    );
        wide_count_t sum;
        wide_count_t lim;
        sum = wide_count_t'(a) + wide_count_t'(b);
        lim = (wide_count_t'(1) << width) - wide_count_t'(1);
        if (sum > lim) begin
            sum = lim;
        end
        return sum[C_MAX_COUNT_WIDTH-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_element_counter_keep_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : keep_popcount
//  Description : Combinational count of set bits in a keep vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module keep_popcount #(
    parameter int unsigned NUM_ELEMENTS = 4,
    parameter int unsigned PC_WIDTH     = $clog2(NUM_ELEMENTS + 1)
) (
    input  logic [NUM_ELEMENTS-1:0] i_keep,
    output logic [PC_WIDTH-1:0]     o_count
);

    logic [PC_WIDTH-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            w_sum = w_sum + PC_WIDTH'(i_keep[i]);
        end
    end

    assign o_count = w_sum;

endmodule
`default_nettype wire

// File: rtl/stream_element_counter.sv
`default_nettype none
// ============================================================================
//  Module      : stream_element_counter
//  Description : Forwards an ndata stream through one register slice and
//                reports the number of kept elements per stream on a side port.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_element_counter
    import stream_element_counter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_ELEMENTS = 4,
    parameter int unsigned COUNT_WIDTH  = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] i_data,
    input  logic [NUM_ELEMENTS-1:0]                 i_keep,
    input  logic                                    i_last,
    input  logic                                    i_valid,
    output logic                                    o_ready,
    output logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] o_data,
    output logic [NUM_ELEMENTS-1:0]                 o_keep,
    output logic                                    o_last,
    output logic                                    o_valid,
    input  logic                                    i_ready,
    output logic [COUNT_WIDTH-1:0]                  o_count_data,
    output logic                                    o_count_valid,
    input  logic                                    i_count_ready
);

    localparam int unsigned C_PC_WIDTH = $clog2(NUM_ELEMENTS + 1);

    logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] r_out_data;
    logic [NUM_ELEMENTS-1:0]                 r_out_keep;
    logic                                    r_out_last;
    logic                                    r_out_valid;
    logic [COUNT_WIDTH-1:0]                  r_count_data;
    logic                                    r_count_valid;
    logic [COUNT_WIDTH-1:0]                  r_acc;
    logic                                    r_sat;

    logic [C_PC_WIDTH-1:0]  w_pc;
    logic                   w_accept;
    count_t                 w_sum_full;
    logic [COUNT_WIDTH-1:0] w_sum;

    keep_popcount #(
        .NUM_ELEMENTS (NUM_ELEMENTS),
        .PC_WIDTH     (C_PC_WIDTH)
    ) u_keep_popcount (
        .i_keep  (i_keep),
        .o_count (w_pc)
    );

    // A last beat may only enter when the count slot is free or draining.
    assign o_ready  = (!r_out_valid || i_ready) &&
                      (!i_last || !r_count_valid || i_count_ready);
    assign w_accept = i_valid && o_ready;

    assign w_sum_full = sat_add(count_t'(r_acc), count_t'(w_pc), COUNT_WIDTH);
    assign w_sum      = r_sat ? {COUNT_WIDTH{1'b1}} : w_sum_full[COUNT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (i_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_out_data <= i_data;
            r_out_keep <= i_keep;
            r_out_last <= i_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (w_accept) begin
            if (i_last) begin
                r_acc <= '0;
                r_sat <= 1'b0;
            end else begin
                r_acc <= w_sum;
                r_sat <= (w_sum == {COUNT_WIDTH{1'b1}});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_valid <= 1'b0;
        end else if (w_accept && i_last) begin
            r_count_valid <= 1'b1;
        end else if (i_count_ready) begin
            r_count_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && i_last) begin
            r_count_data <= w_sum;
        end
    end

    assign o_data        = r_out_data;
    assign o_keep        = r_out_keep;
    assign o_last        = r_out_last;
    assign o_valid       = r_out_valid;
    assign o_count_data  = r_count_data;
    assign o_count_valid = r_count_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_element_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_element_counter
//  Description : Directed and random bench for stream_element_counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_element_counter;

    localparam int N  = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [N-1:0][DW-1:0] data;
        logic [N-1:0]         keep;
        logic                 last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0][DW-1:0] i_data = '0;
    logic [N-1:0]         i_keep = '0;
    logic                 i_last = 1'b0;
    logic                 i_valid = 1'b0;
    logic                 i_ready = 1'b1;
    logic                 i_count_ready = 1'b1;

    logic                 o_ready, o_last, o_valid, o_count_valid;
    logic [N-1:0][DW-1:0] o_data;
    logic [N-1:0]         o_keep;
    logic [31:0]          o_count_data;

    logic                 o4_ready, o4_last, o4_valid, o4_count_valid;
    logic [N-1:0][DW-1:0] o4_data;
    logic [N-1:0]         o4_keep;
    logic [3:0]           o4_count_data;

    stream_element_counter #(.DATA_WIDTH(DW), .NUM_ELEMENTS(N), .COUNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_data(i_data), .i_keep(i_keep), .i_last(i_last), .i_valid(i_valid), .o_ready(o_ready),
        .o_data(o_data), .o_keep(o_keep), .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready),
        .o_count_data(o_count_data), .o_count_valid(o_count_valid), .i_count_ready(i_count_ready)
    );

    stream_element_counter #(.DATA_WIDTH(DW), .NUM_ELEMENTS(N), .COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .i_data(i_data), .i_keep(i_keep), .i_last(i_last), .i_valid(i_valid), .o_ready(o4_ready),
        .o_data(o4_data), .o_keep(o4_keep), .o_last(o4_last), .o_valid(o4_valid), .i_ready(i_ready),
        .o_count_data(o4_count_data), .o_count_valid(o4_count_valid), .i_count_ready(i_count_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [139:0] got, input logic [139:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: queues of expected beats and counts, unbounded element sum.
    beat_t       oq[$];
    logic [31:0] cq[$];
    logic [3:0]  cq4[$];
    logic [31:0] got_log[$];
    longint      acc_m = 0;
    int          n_counts = 0;
    logic [31:0] last_count = '0;
    logic [3:0]  last_count4 = '0;
    logic        hold_o = 1'b0, hold_c = 1'b0;
    beat_t       held_beat;
    logic [31:0] held_count;
    logic        rnd = 1'b0;

    always @(posedge clk) begin
        beat_t e;
        if (rst) begin
            oq.delete(); cq.delete(); cq4.delete();
            acc_m  = 0;
            hold_o = 1'b0;
            hold_c = 1'b0;
        end else begin
            if (hold_o) check("out_stable", {o_valid, o_data, o_keep, o_last}, {1'b1, held_beat});
            if (hold_c) check("count_stable", {o_count_valid, o_count_data}, {1'b1, held_count});
            if (i_valid && o_ready) begin
                oq.push_back('{data: i_data, keep: i_keep, last: i_last});
                acc_m += $countones(i_keep);
                if (i_last) begin
                    cq.push_back(acc_m > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : acc_m[31:0]);
                    cq4.push_back(acc_m > 15 ? 4'hF : acc_m[3:0]);
                    acc_m = 0;
                end
            end
            if (o_valid && i_ready) begin
                check("out_expected", 140'(oq.size() > 0), 140'(1));
                if (oq.size() > 0) begin
                    e = oq.pop_front();
                    check("out_beat", {o_data, o_keep, o_last}, e);
                end
            end
            if (o_count_valid && i_count_ready) begin
                check("count_expected", 140'(cq.size() > 0), 140'(1));
                if (cq.size() > 0) check("count_data", o_count_data, cq.pop_front());
                n_counts++;
                last_count = o_count_data;
                got_log.push_back(o_count_data);
            end
            if (o4_count_valid && i_count_ready) begin
                check("count4_expected", 140'(cq4.size() > 0), 140'(1));
                if (cq4.size() > 0) check("count4_data", o4_count_data, cq4.pop_front());
                last_count4 = o4_count_data;
            end
            hold_o     = o_valid && !i_ready;
            held_beat  = '{data: o_data, keep: o_keep, last: o_last};
            hold_c     = o_count_valid && !i_count_ready;
            held_count = o_count_data;
        end
    end

    always @(negedge clk) begin
        if (rnd) begin
            i_ready       = ($urandom % 3) != 0;
            i_count_ready = ($urandom % 3) != 0;
        end
    end

    task automatic send_beat(input logic [N-1:0] keep, input logic last);
        logic took;
        int   n;
        i_valid = 1'b1;
        i_keep  = keep;
        i_last  = last;
        for (int k = 0; k < N; k++) i_data[k] = $urandom;
        took = 1'b0;
        n    = 0;
        while (!took && n < 300) begin
            #1 took = o_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("send_accepted", 140'(took), 140'(1));
        i_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [N-1:0] rk;
        int len;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 140'(o_valid), 140'(0));
        check("rst_count_valid", 140'(o_count_valid), 140'(0));
        check("rst_in_ready", 140'(o_ready), 140'(1));
        rst = 1'b0;
        idle(1);

        // Three beats, all ready: count 10 alongside the last out beat.
        send_beat(4'b1111, 1'b0);
        send_beat(4'b1111, 1'b0);
        send_beat(4'b0011, 1'b1);
        check("t1_last_out", 140'(o_valid && o_last), 140'(1));
        check("t1_count_valid", 140'(o_count_valid), 140'(1));
        check("t1_count", 140'(o_count_data), 140'(10));
        base = n_counts;
        idle(3);
        check("t1_one_count", 140'(n_counts - base), 140'(1));

        // Disabled stream.
        send_beat(4'b0000, 1'b1);
        check("t2_out_keep", 140'({o_valid, o_keep, o_last}), 140'(6'b1_0000_1));
        check("t2_count", 140'({o_count_valid, o_count_data}), 140'({1'b1, 32'd0}));
        idle(2);

        // Back-to-back last beats with the count port stalled.
        base = got_log.size();
        i_count_ready = 1'b0;
        send_beat(4'b0001, 1'b1);
        i_valid = 1'b1; i_keep = 4'b0111; i_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1 check("t3_stall", 140'(o_ready), 140'(0));
            @(negedge clk);
        end
        i_count_ready = 1'b1;
        #1 check("t3_release", 140'(o_ready), 140'(1));
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        idle(3);
        check("t3_n_counts", 140'(got_log.size() - base), 140'(2));
        if (got_log.size() >= base + 2) begin
            check("t3_first", 140'(got_log[base]), 140'(1));
            check("t3_second", 140'(got_log[base+1]), 140'(3));
        end

        // Saturation in the narrow instance.
        for (int b = 0; b < 5; b++) send_beat(4'b1111, b == 4);
        idle(2);
        check("t4_count32", 140'(last_count), 140'(20));
        check("t4_count4", 140'(last_count4), 140'(15));

        // Reset in the middle of a stream.
        send_beat(4'b1111, 1'b0);
        send_beat(4'b1111, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_out_valid", 140'(o_valid), 140'(0));
        check("t6_count_valid", 140'(o_count_valid), 140'(0));
        check("t6_count4_valid", 140'(o4_count_valid), 140'(0));
        rst = 1'b0;
        send_beat(4'b0011, 1'b1);
        idle(2);
        check("t6_count", 140'(last_count), 140'(2));

        // Random streams with random back-pressure.
        base = n_counts;
        rnd  = 1'b1;
        for (int s = 0; s < 1000; s++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                rk = N'($urandom);
                send_beat(rk, b == len - 1);
                if ($urandom % 4 == 0) idle(1);
            end
        end
        @(negedge clk);
        rnd           = 1'b0;
        i_ready       = 1'b1;
        i_count_ready = 1'b1;
        idle(10);
        check("t5_counts", 140'(n_counts - base), 140'(1000));
        check("t5_out_drained", 140'(oq.size()), 140'(0));
        check("t5_count_drained", 140'(cq.size()), 140'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
